// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: datapath widths, opcode field position and
// the fetch FSM state encoding reused by Control and later decode stages.
package fetch_stage_pkg;

  localparam int PC_W       = 64;
  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with a one-entry hold buffer that catches a fetch
// response arriving while decode is stalled.
module fetch_stage_ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter int PC_W    = fetch_stage_pkg::PC_W,
  parameter int INSTR_W = fetch_stage_pkg::INSTR_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_loadDirect,
  input  logic               i_captureHold,
  input  logic               i_moveHold,
  input  logic               i_stall,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic               r_holdValid;
  logic [INSTR_W-1:0] r_holdInstr;
  logic [PC_W-1:0]    r_holdPc;

  // A flush only invalidates; the stale payload is harmless once valid drops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid     <= 1'b0;
      r_instr     <= '0;
      r_pc        <= '0;
      r_holdValid <= 1'b0;
      r_holdInstr <= '0;
      r_holdPc    <= '0;
    end else if (i_flush) begin
      r_valid     <= 1'b0;
      r_holdValid <= 1'b0;
    end else begin
      if (i_loadDirect) begin
        r_instr <= i_instr;
        r_pc    <= i_pc;
        r_valid <= 1'b1;
      end else if (i_moveHold && r_holdValid) begin
        r_instr     <= r_holdInstr;
        r_pc        <= r_holdPc;
        r_valid     <= 1'b1;
        r_holdValid <= 1'b0;
      end else if (r_valid && !i_stall) begin
        r_valid <= 1'b0;
      end
      if (i_captureHold) begin
        r_holdInstr <= i_instr;
        r_holdPc    <= i_pc;
        r_holdValid <= 1'b1;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch stage: owns the PC, runs the single-outstanding
// request/grant/response handshake and feeds the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PC_W     = fetch_stage_pkg::PC_W,
  parameter int              INSTR_W  = fetch_stage_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                Clk,
  input  logic                Rst_n,
  output logic                IMemReq,
  output logic [PC_W-1:0]     IMemAddr,
  input  logic                IMemGnt,
  input  logic                IMemRspValid,
  input  logic [INSTR_W-1:0]  IMemRdata,
  input  logic                Stall,
  input  logic                BranchTaken,
  input  logic [PC_W-1:0]     BranchTarget,
  output logic                IfIdValid,
  output logic [INSTR_W-1:0]  IfIdInstr,
  output logic [PC_W-1:0]     IfIdPC,
  output logic [OPCODE_W-1:0] OPCode
);

  fetch_state_e    r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_drop;
  logic            r_req;

  logic            w_hs;
  logic            w_canLoad;
  logic            w_rspLive;
  logic            w_loadDirect;
  logic            w_captureHold;
  logic            w_moveHold;
  logic [PC_W-1:0] w_pcNext;
  logic [PC_W-1:0] w_target;

  assign w_pcNext  = r_pc + PC_W'(4);
  assign w_target  = BranchTarget & ~PC_W'(3);
  assign w_hs      = r_req & IMemGnt;
  assign w_canLoad = !IfIdValid || !Stall;

  // Responses only count in WAIT, without a pending drop and outside a redirect.
  assign w_rspLive     = !BranchTaken && (r_state == S_WAIT) && IMemRspValid && !r_drop;
  assign w_loadDirect  = w_rspLive && w_canLoad;
  assign w_captureHold = w_rspLive && !w_canLoad;
  assign w_moveHold    = !BranchTaken && (r_state == S_HOLD) && w_canLoad;

  // r_req is registered and low in reset, so the first request follows one cycle after release.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
      r_req   <= 1'b0;
    end else if (BranchTaken) begin
      r_pc <= w_target;
      if (((r_state == S_WAIT) && !IMemRspValid) || ((r_state == S_FETCH) && w_hs)) begin
        r_drop  <= 1'b1;
        r_state <= S_WAIT;
        r_req   <= 1'b0;
      end else begin
        r_drop  <= 1'b0;
        r_state <= S_FETCH;
        r_req   <= 1'b1;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_hs) begin
            r_state <= S_WAIT;
            r_req   <= 1'b0;
          end else begin
            r_req <= 1'b1;
          end
        end
        S_WAIT: begin
          if (IMemRspValid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= S_FETCH;
              r_req   <= 1'b1;
            end else if (w_canLoad) begin
              r_pc    <= w_pcNext;
              r_state <= S_FETCH;
              r_req   <= 1'b1;
            end else begin
              r_pc    <= w_pcNext;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_canLoad) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_FETCH;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  fetch_stage_ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .i_clk         (Clk),
    .i_rst_n       (Rst_n),
    .i_flush       (BranchTaken),
    .i_loadDirect  (w_loadDirect),
    .i_captureHold (w_captureHold),
    .i_moveHold    (w_moveHold),
    .i_stall       (Stall),
    .i_instr       (IMemRdata),
    .i_pc          (r_pc),
    .o_valid       (IfIdValid),
    .o_instr       (IfIdInstr),
    .o_pc          (IfIdPC)
  );

  assign IMemReq  = r_req;
  assign IMemAddr = r_pc;
  assign OPCode   = IfIdInstr[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level model (expected fetch
// PC, outstanding request, queue of instructions owed to decode) checks every cycle.
module tb_fetch_stage;

  localparam logic [63:0] RESET_PC = 64'h1000;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRspValid;
  logic [31:0] IMemRdata;
  logic        Stall;
  logic        BranchTaken;
  logic [63:0] BranchTarget;
  logic        IfIdValid;
  logic [31:0] IfIdInstr;
  logic [63:0] IfIdPC;
  logic [10:0] OPCode;

  always #5 Clk = ~Clk;

  fetch_stage #(
    .PC_W     (64),
    .INSTR_W  (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemGnt      (IMemGnt),
    .IMemRspValid (IMemRspValid),
    .IMemRdata    (IMemRdata),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .IfIdValid    (IfIdValid),
    .IfIdInstr    (IfIdInstr),
    .IfIdPC       (IfIdPC),
    .OPCode       (OPCode)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Instructions decode is owed, oldest first; the front one must sit in IF/ID.
  entry_t      mQ[$];
  logic [63:0] mPc;
  logic [63:0] mOutAddr;
  bit          mArmed;
  bit          mOut;
  bit          mKilled;
  int          mAge;
  int          mDelay;
  int          rspDelay = 1;
  bit          spurious = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    logic [31:0] w;
    if (a == 64'h1000) w = 32'hF840_0000;
    else w = (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mPc     = RESET_PC;
    mArmed  = 1'b0;
    mOut    = 1'b0;
    mKilled = 1'b0;
    mAge    = 0;
    mDelay  = 1;
  endtask

  function automatic bit expectReq();
    return mArmed && !mOut && (mQ.size() < 2);
  endfunction

  task automatic compareModel();
    entry_t e;
    checkOutput("req", 64'(IMemReq), 64'(expectReq()));
    if (expectReq()) checkOutput("addr", IMemAddr, mPc);
    checkOutput("ifid_valid", 64'(IfIdValid), 64'(mQ.size() != 0));
    if (mQ.size() != 0) begin
      e = mQ[0];
      checkOutput("ifid_pc", IfIdPC, e.pc);
      checkOutput("ifid_instr", 64'(IfIdInstr), 64'(e.instr));
      checkOutput("opcode", 64'(OPCode), 64'(e.instr[31:21]));
    end
  endtask

  // Check the state left by the previous edge, drive this cycle, then advance the model.
  task automatic runCycle(input bit gnt, input bit stall, input bit br, input logic [63:0] tgt);
    bit     hs;
    bit     rsp;
    entry_t e;
    compareModel();
    hs  = expectReq() && gnt;
    rsp = mOut && (mAge >= mDelay);
    IMemGnt      = gnt;
    IMemRspValid = rsp | spurious;
    IMemRdata    = rsp ? memWord(mOutAddr) : $urandom;
    Stall        = stall;
    BranchTaken  = br;
    BranchTarget = tgt;
    if (mOut && !rsp) mAge++;
    if (br) begin
      mQ.delete();
      if (rsp) mOut = 1'b0;
      else if (mOut) mKilled = 1'b1;
      mPc = tgt & ~64'h3;
      if (hs) begin
        mOut = 1'b1; mKilled = 1'b1; mAge = 1; mDelay = rspDelay;
      end
    end else begin
      if (mQ.size() != 0 && !stall) void'(mQ.pop_front());
      if (rsp) begin
        mOut = 1'b0;
        if (!mKilled) begin
          e.pc = mOutAddr;
          e.instr = memWord(mOutAddr);
          mQ.push_back(e);
          mPc = mOutAddr + 64'd4;
        end
      end
      if (hs) begin
        mOut = 1'b1; mKilled = 1'b0; mOutAddr = mPc; mAge = 1; mDelay = rspDelay;
      end
    end
    mArmed = 1'b1;
  endtask

  task automatic applyStimulus(input bit gnt, input bit stall, input bit br, input logic [63:0] tgt);
    @(negedge Clk);
    runCycle(gnt, stall, br, tgt);
  endtask

  task automatic settle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n = 1'b0;
    IMemGnt = 1'b0; IMemRspValid = 1'b0; IMemRdata = '0;
    Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    modelReset();
    repeat (2) @(negedge Clk);
    checkOutput("rst_req", 64'(IMemReq), 64'd0);
    checkOutput("rst_valid", 64'(IfIdValid), 64'd0);
    checkOutput("rst_instr", 64'(IfIdInstr), 64'd0);
    checkOutput("rst_pc", IfIdPC, 64'd0);
    checkOutput("rst_fetch_addr", IMemAddr, RESET_PC);
    Rst_n = 1'b1;
    runCycle(1'b1, 1'b0, 1'b0, '0);

    // First fetch: grant now, LDUR returned next cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    settle();
    checkOutput("ldur_valid", 64'(IfIdValid), 64'd1);
    checkOutput("ldur_pc", IfIdPC, 64'h1000);
    checkOutput("ldur_opcode", 64'(OPCode), 64'b11111000010);
    checkOutput("ldur_next_addr", IMemAddr, 64'h1004);

    // Second instruction returns under stall and parks in the hold buffer.
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    settle();
    checkOutput("hold_no_req", 64'(IMemReq), 64'd0);
    checkOutput("hold_ifid_pc", IfIdPC, 64'h1000);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    settle();
    checkOutput("unstall_pc", IfIdPC, 64'h1004);
    checkOutput("unstall_instr", 64'(IfIdInstr), 64'(memWord(64'h1004)));
    checkOutput("unstall_addr", IMemAddr, 64'h1008);

    // Grant withheld: request must stay put.
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      settle();
      checkOutput("nogrant_req", 64'(IMemReq), 64'd1);
      checkOutput("nogrant_addr", IMemAddr, 64'h1008);
    end

    // Redirect while waiting: orphan response must be dropped.
    rspDelay = 2;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h2003);
    settle();
    checkOutput("br_wait_valid", 64'(IfIdValid), 64'd0);
    checkOutput("br_wait_req", 64'(IMemReq), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    settle();
    checkOutput("drop_valid", 64'(IfIdValid), 64'd0);
    checkOutput("drop_req", 64'(IMemReq), 64'd1);
    checkOutput("drop_addr", IMemAddr, 64'h2000);

    // Redirect coinciding with the response: no drop, straight to target.
    rspDelay = 1;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h3000);
    settle();
    checkOutput("br_rsp_valid", 64'(IfIdValid), 64'd0);
    checkOutput("br_rsp_req", 64'(IMemReq), 64'd1);
    checkOutput("br_rsp_addr", IMemAddr, 64'h3000);

    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    settle();
    checkOutput("wrap_pc", IfIdPC, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_addr", IMemAddr, 64'h0);

    // Reset mid-transaction, then a stray response after release.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", 64'(IMemReq), 64'd0);
    checkOutput("midrst_valid", 64'(IfIdValid), 64'd0);
    checkOutput("midrst_pc", IfIdPC, 64'd0);
    checkOutput("midrst_addr", IMemAddr, RESET_PC);
    modelReset();
    IMemGnt = 1'b0; IMemRspValid = 1'b0; Stall = 1'b0; BranchTaken = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    spurious = 1'b1;
    runCycle(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    spurious = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rspDelay = $urandom_range(1, 3);
      applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 99) < 4, {$urandom, $urandom});
    end
    @(negedge Clk);
    compareModel();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage and IF/ID pipeline register for the 64-bit LEGv8 datapath. It sits directly upstream of the Control decoder. It owns the PC and issues word fetches to instruction memory over a request/grant/response handshake. It buffers returned instructions and presents instruction, PC and the 11-bit OPCode field (Instr[31:21]) to decode. Branch redirects (CBZ/B resolved downstream) flush in-flight work.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
PC_W, 64, PC and address width.
INSTR_W, 32, instruction width.

Ports:
Clk  in  1  clock, all state updates on posedge.
Rst_n  in  1  asynchronous active-low reset.
IMemReq  out  1  fetch request valid.
IMemAddr  out  PC_W  fetch address, word aligned.
IMemGnt  in  1  memory accepts request this cycle (handshake when IMemReq & IMemGnt).
IMemRspValid  in  1  instruction data valid, at least 1 cycle after grant.
IMemRdata  in  INSTR_W  returned instruction.
Stall  in  1  decode cannot accept a new IF/ID entry.
BranchTaken  in  1  redirect strobe, one cycle.
BranchTarget  in  PC_W  redirect address.
IfIdValid  out  1  IF/ID entry valid.
IfIdInstr  out  INSTR_W  registered instruction.
IfIdPC  out  PC_W  PC of IfIdInstr.
OPCode  out  11  IfIdInstr[31:21], combinational from the register, feeds Control.

Behaviour:
- Reset, asynchronous: PC=RESET_PC, state=FETCH, IfIdValid=0, IfIdInstr=0, IfIdPC=0, drop flag=0, IMemReq=0 during reset.
- At most one outstanding request.
- FSM states FETCH, WAIT, HOLD:
  - FETCH: IMemReq=1, IMemAddr=PC. On IMemGnt go to WAIT; otherwise hold the request stable.
  - WAIT: IMemReq=0. On IMemRspValid:
    - If drop=1: discard the data, clear drop, go to FETCH.
    - Else if IF/ID can load (!IfIdValid or !Stall): load IfIdInstr=IMemRdata, IfIdPC=PC, IfIdValid=1, PC<=PC+4, go to FETCH.
    - Else: capture the data in the hold buffer, PC<=PC+4, go to HOLD.
  - HOLD: IMemReq=0. When IF/ID can load, move the buffer into IF/ID and go to FETCH.
- IF/ID consumption: when IfIdValid & !Stall and nothing new loads, IfIdValid<=0 next cycle.
- Best-case throughput is one instruction every 2 cycles (grant, then response). Fetch-to-IfIdValid latency is 1 cycle after IMemRspValid.
- Redirect (BranchTaken=1) has priority over every other event in the same cycle:
  - PC<=BranchTarget with bits [1:0] forced to 0.
  - IfIdValid<=0 and the hold buffer is emptied.
  - If in WAIT, or in FETCH with IMemGnt=1 that cycle: drop<=1, state<=WAIT, so the orphan response is discarded.
  - Otherwise state<=FETCH.
  - If a response arrives in the redirect cycle, it is discarded and drop is not set.
- PC increment wraps modulo 2^PC_W; no fault.
- Stall held indefinitely: IF/ID and the hold buffer keep their values, and no new request is issued.
- Reset asserted mid-transaction returns all state to reset values immediately. A response that arrives after reset release without a matching request is ignored in FETCH.

Decomposition:
- Shared package holds PC_W, INSTR_W, the OPCODE_MSB/LSB field positions (31/21), and the fetch FSM state encoding, so Control and later decode stages reuse them.
- One natural sub-module: ifid_reg, the IF/ID register plus the one-entry hold buffer with load/flush/stall controls. The FSM and PC stay in fetch_stage.

Test Plan:
- Reset with RESET_PC=0x1000, memory grants immediately and responds next cycle with 0xF8400000 (LDUR): IfIdValid=1, IfIdPC=0x1000, OPCode=11'b11111000010, next IMemAddr=0x1004.
- Stall=1 for 5 cycles while the second instruction returns: it sits in the hold buffer with no new IMemReq. After Stall falls, IfIdInstr updates and the PC of the next request is 0x1008.
- BranchTaken=1 with BranchTarget=0x2003 while in WAIT: the next response is discarded, IfIdValid=0, and the next request has IMemAddr=0x2000.
- BranchTaken in the same cycle as IMemRspValid: the response is discarded, no drop is set, and the next request goes to the target.
- Grant withheld 3 cycles: IMemReq and IMemAddr stay stable and the PC does not change.
- PC=0xFFFF_FFFF_FFFF_FFFC fetch completes: the next IMemAddr is 0x0.
